// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA write-command arbiter.
// Index width covers the largest supported requester count.
package dma_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int IDX_W    = $clog2(MAX_REQ);
  localparam int STATUS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } arb_state_e;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] j;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % n);
      if (k < n && !found && req[j]) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// In-order record of granted requester indices awaiting DMA status.
// Extra pointer bit distinguishes full from empty.
module arb_order_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dma_wr_cmd_arbiter.sv
// Round-robin share of one DMA write channel; grant held through burst,
// status returned to issuers in command order.
module dma_wr_cmd_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int ORDER_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              s_cmd_valid,
  output logic [NUM_REQ-1:0]              s_cmd_ready,
  input  logic [NUM_REQ*64-1:0]           s_cmd_address,
  input  logic [NUM_REQ*32-1:0]           s_cmd_length,
  input  logic [NUM_REQ-1:0]              s_data_valid,
  output logic [NUM_REQ-1:0]              s_data_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_data_keep,
  input  logic [NUM_REQ-1:0]              s_data_last,
  output logic [NUM_REQ-1:0]              s_status_valid,
  input  logic [NUM_REQ-1:0]              s_status_ready,
  output logic [STATUS_W-1:0]             s_status_data,
  output logic                            m_cmd_valid,
  input  logic                            m_cmd_ready,
  output logic [63:0]                     m_cmd_address,
  output logic [31:0]                     m_cmd_length,
  output logic                            m_data_valid,
  input  logic                            m_data_ready,
  output logic [DATA_WIDTH-1:0]           m_data_data,
  output logic [DATA_WIDTH/8-1:0]         m_data_keep,
  output logic                            m_data_last,
  input  logic                            m_status_valid,
  output logic                            m_status_ready,
  input  logic [STATUS_W-1:0]             m_status_data
);

  localparam int KW = DATA_WIDTH / 8;

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] rr_nxt;
  logic [IDX_W-1:0] head;

  logic [MAX_REQ-1:0] cvalid_pad;
  logic [MAX_REQ-1:0] dvalid_pad;
  logic [MAX_REQ-1:0] dlast_pad;
  logic [MAX_REQ-1:0] sready_pad;

  logic        grant_ok;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [63:0] sel_addr;
  logic [31:0] sel_len;

  assign cvalid_pad = MAX_REQ'(s_cmd_valid);
  assign dvalid_pad = MAX_REQ'(s_data_valid);
  assign dlast_pad  = MAX_REQ'(s_data_last);
  assign sready_pad = MAX_REQ'(s_status_ready);

  assign pick     = rr_pick(cvalid_pad, rr_ptr, NUM_REQ);
  assign grant_ok = (state == IDLE) && (|s_cmd_valid) && !full;
  assign sel_addr = s_cmd_address[pick*64 +: 64];
  assign sel_len  = s_cmd_length[pick*32 +: 32];

  assign rr_nxt = (gnt == IDX_W'(NUM_REQ - 1)) ?
                  '0 : gnt + 1'b1;

  assign push = (state == CMD) && m_cmd_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      gnt           <= '0;
      m_cmd_valid   <= 1'b0;
      m_cmd_address <= '0;
      m_cmd_length  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_ok) begin
            gnt           <= pick;
            m_cmd_address <= sel_addr;
            m_cmd_length  <= sel_len;
            m_cmd_valid   <= 1'b1;
            state         <= CMD;
          end
        end
        CMD: begin
          if (m_cmd_ready) begin
            m_cmd_valid <= 1'b0;
            rr_ptr      <= rr_nxt;
            // Zero-length writes carry no data beats.
            state <= (m_cmd_length == '0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (m_data_valid && m_data_ready && m_data_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_cmd_ready  = '0;
    s_data_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_cmd_ready[i]  = grant_ok && (pick == IDX_W'(i));
      s_data_ready[i] = (state == DATA) && m_data_ready &&
                        (gnt == IDX_W'(i));
    end
  end

  assign m_data_valid = (state == DATA) && dvalid_pad[gnt];
  assign m_data_last  = dlast_pad[gnt];
  assign m_data_data  = s_data_data[gnt*DATA_WIDTH +: DATA_WIDTH];
  assign m_data_keep  = s_data_keep[gnt*KW +: KW];

  // A status with no outstanding command is held off, never dropped.
  assign m_status_ready = !empty && sready_pad[head];
  assign pop            = m_status_valid && m_status_ready;
  assign s_status_data  = m_status_data;

  always_comb begin
    s_status_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      s_status_valid[i] = m_status_valid && !empty &&
                          (head == IDX_W'(i));
  end

  arb_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .W     (IDX_W)
  ) u_order (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (gnt),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: tb/tb_dma_wr_cmd_arbiter.sv
// Directed bench for dma_wr_cmd_arbiter with hand-derived expectations.
module tb_dma_wr_cmd_arbiter;

  localparam int NR = 4;
  localparam int DW = 512;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     s_cmd_valid;
  logic [NR-1:0]     s_cmd_ready;
  logic [NR*64-1:0]  s_cmd_address;
  logic [NR*32-1:0]  s_cmd_length;
  logic [NR-1:0]     s_data_valid;
  logic [NR-1:0]     s_data_ready;
  logic [NR*DW-1:0]  s_data_data;
  logic [NR*DW/8-1:0] s_data_keep;
  logic [NR-1:0]     s_data_last;
  logic [NR-1:0]     s_status_valid;
  logic [NR-1:0]     s_status_ready;
  logic [7:0]        s_status_data;
  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic [63:0]       m_cmd_address;
  logic [31:0]       m_cmd_length;
  logic              m_data_valid;
  logic              m_data_ready;
  logic [DW-1:0]     m_data_data;
  logic [DW/8-1:0]   m_data_keep;
  logic              m_data_last;
  logic              m_status_valid;
  logic              m_status_ready;
  logic [7:0]        m_status_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_wr_cmd_arbiter #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .ORDER_DEPTH (16)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_cmd_valid    (s_cmd_valid),
    .s_cmd_ready    (s_cmd_ready),
    .s_cmd_address  (s_cmd_address),
    .s_cmd_length   (s_cmd_length),
    .s_data_valid   (s_data_valid),
    .s_data_ready   (s_data_ready),
    .s_data_data    (s_data_data),
    .s_data_keep    (s_data_keep),
    .s_data_last    (s_data_last),
    .s_status_valid (s_status_valid),
    .s_status_ready (s_status_ready),
    .s_status_data  (s_status_data),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_address  (m_cmd_address),
    .m_cmd_length   (m_cmd_length),
    .m_data_valid   (m_data_valid),
    .m_data_ready   (m_data_ready),
    .m_data_data    (m_data_data),
    .m_data_keep    (m_data_keep),
    .m_data_last    (m_data_last),
    .m_status_valid (m_status_valid),
    .m_status_ready (m_status_ready),
    .m_status_data  (m_status_data)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    s_cmd_valid    = '0;
    s_cmd_address  = '0;
    s_cmd_length   = '0;
    s_data_valid   = '0;
    s_data_data    = '0;
    s_data_keep    = '0;
    s_data_last    = '0;
    s_status_ready = '1;
    m_cmd_ready    = 1'b0;
    m_data_ready   = 1'b0;
    m_status_valid = 1'b0;
    m_status_data  = '0;
    step();
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [63:0] a,
                         input logic [31:0] l);
    s_cmd_address[i*64 +: 64] = a;
    s_cmd_length[i*32 +: 32]  = l;
  endtask

  // Grant for requester g, cmd handshake, then beats 1-beat bursts.
  task automatic do_grant(input int g, input int beats);
    #1;
    chk("grant_rdy", 64'(s_cmd_ready), 64'(1 << g));
    step();
    chk("cmd_valid", 64'(m_cmd_valid), 64'd1);
    chk("cmd_addr", m_cmd_address, 64'h100 * (g + 1));
    m_cmd_ready = 1'b1;
    step();
    m_cmd_ready = 1'b0;
    #1;
    for (int b = 0; b < beats; b++) begin
      chk("mux_data", 64'(m_data_data[7:0]), 64'(8'hD0 + g));
      chk("mux_rdy", 64'(s_data_ready), 64'(1 << g));
      step();
    end
  endtask

  initial begin
    // 1: single 2-beat write from req0
    do_reset();
    chk("rst_cmd_valid", 64'(m_cmd_valid), 64'd0);
    chk("rst_cmd_addr", m_cmd_address, 64'd0);
    chk("rst_cmd_len", 64'(m_cmd_length), 64'd0);
    chk("rst_dvalid", 64'(m_data_valid), 64'd0);
    chk("rst_sready", 64'(m_status_ready), 64'd0);
    set_cmd(0, 64'h1000, 32'd128);
    s_cmd_valid = 4'b0001;
    #1;
    chk("t1_grant", 64'(s_cmd_ready), 64'h1);
    step();
    s_cmd_valid = '0;
    #1;
    chk("t1_cmd_valid", 64'(m_cmd_valid), 64'd1);
    chk("t1_cmd_addr", m_cmd_address, 64'h1000);
    chk("t1_cmd_len", 64'(m_cmd_length), 64'd128);
    chk("t1_no_regrant", 64'(s_cmd_ready), 64'h0);
    step();
    chk("t1_cmd_hold", 64'(m_cmd_valid), 64'd1);
    m_cmd_ready = 1'b1;
    step();
    m_cmd_ready = 1'b0;
    #1;
    chk("t1_cmd_drop", 64'(m_cmd_valid), 64'd0);
    s_data_valid = 4'b0001;
    s_data_data[7:0] = 8'hA1;
    s_data_last  = 4'b0000;
    m_data_ready = 1'b1;
    #1;
    chk("t1_b1_valid", 64'(m_data_valid), 64'd1);
    chk("t1_b1_data", 64'(m_data_data[7:0]), 64'hA1);
    chk("t1_b1_last", 64'(m_data_last), 64'd0);
    chk("t1_b1_rdy", 64'(s_data_ready), 64'h1);
    step();
    s_data_data[7:0] = 8'hB2;
    s_data_last = 4'b0001;
    #1;
    chk("t1_b2_data", 64'(m_data_data[7:0]), 64'hB2);
    chk("t1_b2_last", 64'(m_data_last), 64'd1);
    step();
    s_data_valid = '0;
    #1;
    chk("t1_idle_dvalid", 64'(m_data_valid), 64'd0);
    m_status_valid = 1'b1;
    m_status_data  = 8'h55;
    #1;
    chk("t1_st_route", 64'(s_status_valid), 64'h1);
    chk("t1_st_data", 64'(s_status_data), 64'h55);
    chk("t1_st_rdy", 64'(m_status_ready), 64'd1);
    step();
    #1;
    chk("t1_st_empty_rdy", 64'(m_status_ready), 64'd0);
    chk("t1_st_empty_vld", 64'(s_status_valid), 64'h0);
    m_status_valid = 1'b0;

    // 2: all four requesting, single-beat bursts
    do_reset();
    for (int i = 0; i < NR; i++) begin
      set_cmd(i, 64'h100 * (i + 1), 32'd64);
      s_data_data[i*DW +: 8] = 8'hD0 + 8'(i);
    end
    s_cmd_valid  = '1;
    s_data_valid = '1;
    s_data_last  = '1;
    m_data_ready = 1'b1;
    do_grant(0, 1);
    do_grant(1, 1);
    do_grant(2, 1);
    do_grant(3, 1);
    do_grant(0, 1);

    // 3: zero-length command from req1
    do_reset();
    set_cmd(1, 64'h200, 32'd0);
    s_cmd_valid  = 4'b0010;
    s_data_valid = 4'b0010;
    m_data_ready = 1'b1;
    #1;
    chk("t3_grant", 64'(s_cmd_ready), 64'h2);
    step();
    s_cmd_valid = '0;
    chk("t3_cmd_len", 64'(m_cmd_length), 64'd0);
    m_cmd_ready = 1'b1;
    step();
    m_cmd_ready = 1'b0;
    #1;
    chk("t3_no_data", 64'(m_data_valid), 64'd0);
    chk("t3_no_drdy", 64'(s_data_ready), 64'h0);
    s_cmd_valid = 4'b0001;
    #1;
    chk("t3_idle_grant", 64'(s_cmd_ready), 64'h1);
    s_cmd_valid = '0;
    s_data_valid = '0;
    s_status_ready = 4'b1101;
    m_status_valid = 1'b1;
    m_status_data  = 8'h3C;
    #1;
    chk("t3_st_route", 64'(s_status_valid), 64'h2);
    chk("t3_st_backpr", 64'(m_status_ready), 64'd0);
    s_status_ready = '1;
    #1;
    chk("t3_st_rdy", 64'(m_status_ready), 64'd1);
    step();
    m_status_valid = 1'b0;

    // 4: sixteen outstanding commands fill the order FIFO
    do_reset();
    for (int i = 0; i < NR; i++)
      set_cmd(i, 64'h100 * (i + 1), 32'd0);
    s_cmd_valid = '1;
    for (int k = 0; k < 16; k++)
      do_grant(k % NR, 0);
    #1;
    chk("t4_full_block", 64'(s_cmd_ready), 64'h0);
    step();
    chk("t4_full_nocmd", 64'(m_cmd_valid), 64'd0);
    chk("t4_full_block2", 64'(s_cmd_ready), 64'h0);
    m_status_valid = 1'b1;
    #1;
    chk("t4_st_head0", 64'(s_status_valid), 64'h1);
    step();
    m_status_valid = 1'b0;
    #1;
    chk("t4_unblock", 64'(s_cmd_ready), 64'h1);

    // 5: push and pop in the same cycle
    step();
    m_cmd_ready    = 1'b1;
    m_status_valid = 1'b1;
    #1;
    chk("t5_st_head1", 64'(s_status_valid), 64'h2);
    chk("t5_st_rdy", 64'(m_status_ready), 64'd1);
    step();
    m_status_valid = 1'b0;
    #1;
    chk("t5_not_full", 64'(s_cmd_ready), 64'h2);
    step();
    step();
    m_cmd_ready = 1'b0;
    #1;
    chk("t5_full_again", 64'(s_cmd_ready), 64'h0);
    m_status_valid = 1'b1;
    #1;
    chk("t5_st_head2", 64'(s_status_valid), 64'h4);
    m_status_valid = 1'b0;

    // 6: reset during beat 3 of an 8-beat burst
    do_reset();
    set_cmd(2, 64'h300, 32'd512);
    s_cmd_valid = 4'b0100;
    #1;
    chk("t6_grant", 64'(s_cmd_ready), 64'h4);
    step();
    s_cmd_valid = '0;
    m_cmd_ready = 1'b1;
    step();
    m_cmd_ready  = 1'b0;
    s_data_valid = 4'b0100;
    s_data_last  = '0;
    m_data_ready = 1'b1;
    step();
    step();
    #1;
    chk("t6_mid_burst", 64'(m_data_valid), 64'd1);
    rstn = 1'b0;
    step();
    chk("t6_rst_dvalid", 64'(m_data_valid), 64'd0);
    chk("t6_rst_drdy", 64'(s_data_ready), 64'h0);
    chk("t6_rst_cvalid", 64'(m_cmd_valid), 64'd0);
    m_status_valid = 1'b1;
    #1;
    chk("t6_fifo_empty", 64'(m_status_ready), 64'd0);
    chk("t6_st_none", 64'(s_status_valid), 64'h0);
    rstn = 1'b1;
    m_status_valid = 1'b0;
    s_data_valid = '0;
    s_cmd_valid = '1;
    #1;
    chk("t6_rr_zero", 64'(s_cmd_ready), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
